dna_port_scheduler: RTL and testbench

Sequences the FPGA's DNA_PORT primitive and shares the resulting 57-bit device DNA among several on-chip requesters (command decoder, status reporter, etc.). After reset it waits a fixed settling period, loads and shifts out the DNA once, and caches it. It then grants cached copies to requesters round-robin, one grant per cycle. A refresh input forces a re-read, and all grants are held off until that re-read completes.

---
 rtl/dna_port_scheduler_pkg.sv | 12 +
 rtl/dna_port_scheduler_if.sv | 14 +
 rtl/dna_port_scheduler_rr_arbiter.sv | 29 ++
 rtl/dna_port_scheduler.sv | 83 ++++++++
 tb/tb_dna_port_scheduler.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dna_port_scheduler_pkg.sv
// dna_pkg: shared state encoding, status codes and sizing helper for the DNA scheduler.
package dna_pkg;
  typedef enum logic [1:0] {WAIT, LOAD, SHIFT, READY} dna_state_e;
  localparam logic [3:0] DNA_STATUS_BUSY = 4'h0;
  localparam logic [3:0] DNA_STATUS_DONE = 4'h1;
  localparam int DNA_BITS_DEFAULT = 57;
  function automatic int cnt_width(int a, int b);
    int m;
    m = a > b ? a : b;
    return $clog2(m) < 6 ? 6 : $clog2(m);
  endfunction
endpackage

// File: rtl/dna_port_scheduler_if.sv
// dna_port_scheduler_if: requester handshake plus DNA_PORT pins; slave is the scheduler side.
interface dna_port_scheduler_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic refresh;
  logic [63:0] dna_value;
  logic dna_valid;
  logic busy;
  logic dna_read;
  logic dna_shift;
  logic dna_dout;
  modport slave (input req, refresh, dna_dout, output grant, dna_value, dna_valid, busy, dna_read, dna_shift);
  modport master (output req, refresh, dna_dout, input grant, dna_value, dna_valid, busy, dna_read, dna_shift);
endinterface

// File: rtl/dna_port_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; search starts at the pointer, which moves past each winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  logic hit;
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!hit && enable && |(req & (N'(1) << ((int'(ptr_q) + i) % N)))) begin
        grant = N'(1) << ((int'(ptr_q) + i) % N);
        ptr_d = PW'((int'(ptr_q) + i + 1) % N);
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/dna_port_scheduler.sv
// dna_port_scheduler: reads DNA_PORT once after a settling wait, caches the 57-bit DNA
// and hands cached copies to requesters round-robin; refresh forces a re-read.
module dna_port_scheduler
  import dna_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int STARTUP_WAIT = 31,
  parameter int DNA_BITS = DNA_BITS_DEFAULT
) (
  input logic clk,
  input logic reset,
  dna_port_scheduler_if.slave bus
);
  localparam int CW = cnt_width(STARTUP_WAIT, DNA_BITS);
  dna_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [N_REQ-1:0] grant_q, gnt;
  logic [63:0] value_q;
  logic valid_q, busy_q, read_q, shift_q;
  // refresh wins over any pending request in its cycle
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(bus.req),
    .enable(state_q == READY && !bus.refresh),
    .grant(gnt)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= WAIT;
      cnt_q <= CW'(STARTUP_WAIT - 1);
      grant_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b1;
      read_q <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      grant_q <= gnt;
      case (state_q)
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= LOAD;
            value_q <= {DNA_STATUS_BUSY, 60'h0};
            read_q <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= SHIFT;
          cnt_q <= CW'(DNA_BITS - 1);
          read_q <= 1'b0;
          shift_q <= 1'b1;
        end
        SHIFT: begin
          value_q[56:0] <= {value_q[55:0], bus.dna_dout};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= READY;
            shift_q <= 1'b0;
            value_q[63:60] <= DNA_STATUS_DONE;
            valid_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        READY: begin
          if (bus.refresh) begin
            state_q <= LOAD;
            value_q <= {DNA_STATUS_BUSY, 60'h0};
            valid_q <= 1'b0;
            busy_q <= 1'b1;
            read_q <= 1'b1;
          end
        end
      endcase
    end
  assign bus.grant = grant_q;
  assign bus.dna_value = value_q;
  assign bus.dna_valid = valid_q;
  assign bus.busy = busy_q;
  assign bus.dna_read = read_q;
  assign bus.dna_shift = shift_q;
endmodule

// File: tb/tb_dna_port_scheduler.sv
// tb_dna_port_scheduler: two builds (N_REQ=2/WAIT=31 and N_REQ=1/WAIT=1) checked against a
// timeline model: expected outputs derive from cycles elapsed since reset or refresh.
module tb_dna_port_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dna_port_scheduler_if #(.N_REQ(2)) b0();
  dna_port_scheduler_if #(.N_REQ(1)) b1();
  dna_port_scheduler #(.N_REQ(2), .STARTUP_WAIT(31), .DNA_BITS(57)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  dna_port_scheduler #(.N_REQ(1), .STARTUP_WAIT(1), .DNA_BITS(57)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  logic [56:0] dna [2];
  logic [56:0] sr0, sr1;
  always @(posedge clk)
    if (b0.dna_read) sr0 <= dna[0];
    else if (b0.dna_shift) sr0 <= {sr0[55:0], 1'b0};
  always @(posedge clk)
    if (b1.dna_read) sr1 <= dna[1];
    else if (b1.dna_shift) sr1 <= {sr1[55:0], 1'b0};
  assign b0.dna_dout = sr0[56];
  assign b1.dna_dout = sr1[56];
  int sw [2] = '{31, 1};
  int nr [2] = '{2, 1};
  int age [2];
  int ptr [2];
  logic [1:0] egnt [2];
  int checks = 0;
  int fails = 0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit ready(int d);
    return age[d] > sw[d] + 57;
  endfunction
  task automatic check(int d);
    logic [1:0] g;
    logic [63:0] v;
    logic vl, bs, rd, sh;
    g = d == 0 ? b0.grant : {1'b0, b1.grant};
    v = d == 0 ? b0.dna_value : b1.dna_value;
    vl = d == 0 ? b0.dna_valid : b1.dna_valid;
    bs = d == 0 ? b0.busy : b1.busy;
    rd = d == 0 ? b0.dna_read : b1.dna_read;
    sh = d == 0 ? b0.dna_shift : b1.dna_shift;
    chk($sformatf("d%0d_grant", d), 64'(g), 64'(egnt[d]));
    chk($sformatf("d%0d_valid", d), 64'(vl), 64'(ready(d)));
    chk($sformatf("d%0d_busy", d), 64'(bs), 64'(!ready(d)));
    chk($sformatf("d%0d_read", d), 64'(rd), 64'(age[d] == sw[d]));
    chk($sformatf("d%0d_shift", d), 64'(sh), 64'(age[d] > sw[d] && age[d] <= sw[d] + 57));
    if (ready(d)) chk($sformatf("d%0d_value", d), v, {4'h1, 3'b000, dna[d]});
  endtask
  task automatic step();
    logic [1:0] r;
    logic f;
    int idx;
    for (int d = 0; d < 2; d++) begin
      r = d == 0 ? b0.req : {1'b0, b1.req};
      f = d == 0 ? b0.refresh : b1.refresh;
      egnt[d] = '0;
      if (ready(d) && !f)
        for (int k = 0; k < nr[d]; k++) begin
          idx = (ptr[d] + k) % nr[d];
          if (egnt[d] == 2'b00 && ((r >> idx) & 2'b01) != 2'b00) begin
            egnt[d] = 2'(1 << idx);
            ptr[d] = (idx + 1) % nr[d];
          end
        end
      if (ready(d) && f) age[d] = sw[d];
      else if (age[d] < 100000) age[d]++;
    end
    @(posedge clk);
    #1;
    check(0);
    check(1);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      age[d] = 0;
      ptr[d] = 0;
      egnt[d] = '0;
      check(d);
    end
    chk("d0_reset_value", b0.dna_value, 64'h0);
    chk("d1_reset_value", b1.dna_value, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    int rd, sh, fv0, fv1, lc;
    b0.req = 2'b11;
    b0.refresh = 1'b0;
    b1.req = 1'b1;
    b1.refresh = 1'b0;
    dna[0] = 57'h1_2345_6789_ABCD;
    dna[1] = 57'({$urandom(), $urandom()});
    #2;
    do_reset();
    rd = 0;
    sh = 0;
    fv0 = -1;
    fv1 = -1;
    for (int c = 1; c <= 100; c++) begin
      step();
      rd += int'(b0.dna_read);
      sh += int'(b0.dna_shift);
      if (fv0 < 0 && b0.dna_valid) fv0 = c;
      if (fv1 < 0 && b1.dna_valid) fv1 = c;
    end
    chk("read_pulse_len", 64'(rd), 64'd1);
    chk("shift_len", 64'(sh), 64'd57);
    chk("ready_at", 64'(fv0), 64'd89);
    chk("ready_at_n1", 64'(fv1), 64'd59);
    b0.req = 2'b00;
    repeat (3) step();
    b0.req = 2'b10;
    step();
    b0.req = 2'b00;
    step();
    b0.req = 2'b11;
    step();
    b0.req = 2'b00;
    step();
    dna[0] = 57'h0_FFFF_0000_FFFF;
    b0.req = 2'b01;
    b0.refresh = 1'b1;
    step();
    b0.refresh = 1'b0;
    lc = int'(!b0.dna_valid);
    repeat (70) begin
      step();
      lc += int'(!b0.dna_valid);
    end
    chk("refresh_low_len", 64'(lc), 64'd58);
    repeat (300) begin
      b0.req = 2'($urandom_range(0, 3));
      b1.req = 1'($urandom_range(0, 1));
      b0.refresh = 1'b0;
      b1.refresh = 1'b0;
      if (ready(0) && $urandom_range(0, 39) == 0) begin
        dna[0] = 57'({$urandom(), $urandom()});
        b0.refresh = 1'b1;
      end
      if (ready(1) && $urandom_range(0, 39) == 0) begin
        dna[1] = 57'({$urandom(), $urandom()});
        b1.refresh = 1'b1;
      end
      step();
    end
    b0.refresh = 1'b0;
    b1.refresh = 1'b0;
    b0.req = 2'b11;
    b1.req = 1'b1;
    do_reset();
    while (age[0] < 61) step();
    do_reset();
    repeat (100) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
